z80_io_port_bank: RTL

//  Parametrised Z80 I/O port bank: NUM_PORTS data registers decoded from addr_bus[7:0] at BASE_ADDR.

---
 rtl/z80_io_pkg.sv | 13 +
 rtl/z80_io_wait_fsm.sv | 106 ++++++++++
 rtl/z80_io_port_bank.sv | 123 ++++++++++++
 3 files changed

// File: rtl/z80_io_pkg.sv
// Shared types for the Z80 I/O port bank: bus-cycle states and wait counter width.
package z80_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } io_state_e;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/z80_io_wait_fsm.sv
// Bus-cycle sequencer: one access per IORQ_L assertion, optional wait states,
// and a rearm flag so a strobe held across a completed cycle cannot retrigger.
module z80_io_wait_fsm
    import z80_io_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IORQ_L,
    input  logic             RD_L,
    input  logic             WR_L,
    input  logic             req,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] idx_q,
    output logic             do_read,
    output logic             do_write,
    output logic             drive_en,
    output logic             WAIT_L
);

    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    io_state_e              state_r;
    logic [WAIT_CNT_W-1:0]  cnt_r;
    logic                   is_read_r;
    logic [IDX_W-1:0]       idx_r;
    logic                   out_en_r;
    logic                   rearm_r;
    logic                   wait_l_r;

    // Bus-cycle state machine with registered WAIT_L, drive enable and rearm flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            is_read_r <= 1'b0;
            idx_r     <= '0;
            out_en_r  <= 1'b0;
            rearm_r   <= 1'b0;
            wait_l_r  <= 1'b1;
        end else begin
            if (IORQ_L) begin
                rearm_r <= 1'b0;
            end else if (state_r == HOLD) begin
                rearm_r <= 1'b1;
            end else begin
                rearm_r <= rearm_r;
            end

            case (state_r)
                IDLE: begin
                    if (req && !rearm_r) begin
                        idx_r     <= idx;
                        is_read_r <= !RD_L;
                        if (WAIT_CYCLES > 0) begin
                            state_r  <= WAIT;
                            cnt_r    <= CNT_LOAD;
                            wait_l_r <= 1'b0;
                        end else begin
                            state_r  <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    // CPU abandoned the cycle: leave without touching any register
                    if (IORQ_L) begin
                        state_r  <= IDLE;
                        cnt_r    <= '0;
                        wait_l_r <= 1'b1;
                    end else if (cnt_r == '0) begin
                        state_r  <= ACCESS;
                        wait_l_r <= 1'b1;
                    end else begin
                        cnt_r    <= cnt_r - WAIT_CNT_W'(1'b1);
                    end
                end
                ACCESS: begin
                    state_r  <= HOLD;
                    out_en_r <= is_read_r;
                end
                HOLD: begin
                    if (IORQ_L || (is_read_r ? RD_L : WR_L)) begin
                        state_r  <= IDLE;
                        out_en_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= '0;
                    out_en_r <= 1'b0;
                    wait_l_r <= 1'b1;
                end
            endcase
        end
    end

    assign idx_q    = idx_r;
    assign do_read  = (state_r == ACCESS) && is_read_r;
    assign do_write = (state_r == ACCESS) && !is_read_r;
    assign drive_en = out_en_r;
    assign WAIT_L   = wait_l_r;

endmodule

// File: rtl/z80_io_port_bank.sv
// Z80 I/O port bank: decoded port registers with read-only protection,
// a peripheral-side write port and per-port access strobes.
module z80_io_port_bank
    import z80_io_pkg::*;
#(
    parameter int                   DW          = 8,
    parameter int                   NUM_PORTS   = 16,
    parameter logic [7:0]           BASE_ADDR   = 8'h00,
    parameter int                   WAIT_CYCLES = 0,
    parameter logic [NUM_PORTS-1:0] RO_MASK     = '0,
    localparam int                  IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IORQ_L,
    input  logic                    M1_L,
    input  logic                    RD_L,
    input  logic                    WR_L,
    input  logic [15:0]             addr_bus,
    inout  tri   [DW-1:0]           data_bus,
    output logic                    WAIT_L,
    input  logic                    dev_we,
    input  logic [IDX_W-1:0]        dev_sel,
    input  logic [DW-1:0]           dev_wdata,
    output logic [NUM_PORTS*DW-1:0] port_q,
    output logic [NUM_PORTS-1:0]    rd_pulse,
    output logic [NUM_PORTS-1:0]    wr_pulse
);

    function automatic logic [DW-1:0] reset_val(input int i);
        return DW'(int'(BASE_ADDR) + i);
    endfunction

    logic [DW-1:0]        port_r [NUM_PORTS];
    logic [DW-1:0]        out_data_r;
    logic [NUM_PORTS-1:0] rd_pulse_r;
    logic [NUM_PORTS-1:0] wr_pulse_r;
    logic [8:0]           rel_s;
    logic                 hit_s;
    logic                 req_s;
    logic [IDX_W-1:0]     idx_s;
    logic [IDX_W-1:0]     idx_q_s;
    logic                 do_read_s;
    logic                 do_write_s;
    logic                 drive_en_s;
    logic [DW-1:0]        rd_data_s;
    logic                 unused_addr_s;

    // The 9-bit difference goes negative (bit 8 set) for addresses below the base
    assign rel_s         = {1'b0, addr_bus[7:0]} - {1'b0, BASE_ADDR};
    assign hit_s         = !rel_s[8] && (rel_s < 9'(NUM_PORTS));
    assign idx_s         = rel_s[IDX_W-1:0];
    assign req_s         = !IORQ_L && M1_L && (RD_L ^ WR_L) && hit_s;
    assign unused_addr_s = ^addr_bus[15:8];

    z80_io_wait_fsm #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .IDX_W       (IDX_W)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .IORQ_L   (IORQ_L),
        .RD_L     (RD_L),
        .WR_L     (WR_L),
        .req      (req_s),
        .idx      (idx_s),
        .idx_q    (idx_q_s),
        .do_read  (do_read_s),
        .do_write (do_write_s),
        .drive_en (drive_en_s),
        .WAIT_L   (WAIT_L)
    );

    // Read mux over the latched port index
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx_q_s == IDX_W'(i)) begin
                rd_data_s = port_r[i];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Port registers, read capture and strobes; a committed bus write beats a device write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_r[i] <= reset_val(i);
            end
            out_data_r <= '0;
            rd_pulse_r <= '0;
            wr_pulse_r <= '0;
        end else begin
            rd_pulse_r <= '0;
            wr_pulse_r <= '0;
            if (do_read_s) begin
                out_data_r <= rd_data_s;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (do_read_s && (idx_q_s == IDX_W'(i))) begin
                    rd_pulse_r[i] <= 1'b1;
                end
                if (do_write_s && (idx_q_s == IDX_W'(i)) && !RO_MASK[i]) begin
                    port_r[i]     <= data_bus;
                    wr_pulse_r[i] <= 1'b1;
                end else if (dev_we && (dev_sel == IDX_W'(i))) begin
                    port_r[i]     <= dev_wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_q
        assign port_q[g*DW +: DW] = port_r[g];
    end

    assign rd_pulse = rd_pulse_r;
    assign wr_pulse = wr_pulse_r;
    assign data_bus = drive_en_s ? out_data_r : {DW{1'bz}};

endmodule
